// File: rtl/code_lock_fsm_pkg.sv
// Shared constants and state encoding for the combination-lock block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package code_lock_fsm_pkg;

    // Width of one code digit, which matches the comparator operand width
    localparam int DIGIT_W = 2;

    // Lock controller states; encoding 2'd3 is unused and recovers to ST_ENTRY
    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

endpackage

// File: rtl/code_lock_fsm_lockout_timer.sv
// Lockout timer: runs for exactly LOCKOUT_CYC cycles after a start strobe.
// Latency: busy rises the cycle after start; done_pulse is high during the last busy cycle.
// Backpressure: none; start is always accepted and restarts the count.
module lockout_timer #(
    parameter int LOCKOUT_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done_pulse
);

    localparam int CW = $clog2(LOCKOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(LOCKOUT_CYC - 1);

    logic [CW-1:0] lock_cnt;

    // Count elapsed lockout cycles; stop and clear on the final one so the count never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            lock_cnt <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            lock_cnt <= '0;
        end else if (busy) begin
            if (lock_cnt == LAST) begin
                busy     <= 1'b0;
                lock_cnt <= '0;
            end else begin
                lock_cnt <= lock_cnt + 1'b1;
            end
        end
    end

    // Flag the last lockout cycle so the controller leaves on the same edge the timer stops
    assign done_pulse = busy && (lock_cnt == LAST);

endmodule

// File: rtl/code_lock_fsm.sv
// Combination lock: checks each keyed digit via an external comparator, counts failures, enforces a timed lockout.
// Latency: unlock/fail_pulse/locked_out are registered, one cycle after key_pulse; code_digit/digit_idx decode idx directly.
// Backpressure: none; every key_pulse is consumed (ignored in LOCKOUT). Optional hint port: define CODE_LOCK_HINT_EN.
module code_lock_fsm
    import code_lock_fsm_pkg::*;
#(
    parameter int                      CODE_LEN    = 4,
    parameter logic [2*CODE_LEN-1:0]   CODE        = 8'b00_11_01_10,
    parameter int                      MAX_FAIL    = 3,
    parameter int                      LOCKOUT_CYC = 50_000_000
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        key_pulse,
    input  logic                        less,
    input  logic                        equal,
    input  logic                        greater,
    output logic [DIGIT_W-1:0]          code_digit,
    output logic [$clog2(CODE_LEN)-1:0] digit_idx,
    output logic                        unlock,
    output logic                        fail_pulse,
    output logic                        locked_out
`ifdef CODE_LOCK_HINT_EN
    ,
    output logic [1:0]                  hint
`endif
);

    localparam int IW = $clog2(CODE_LEN);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(CODE_LEN - 1);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);

    state_t        state;
    logic [IW-1:0] idx;
    logic [FW-1:0] fail_cnt;
    logic          match;
    logic          state_bad;
    logic          lock_start;
    logic          timer_rst;
    logic          timer_busy;
    logic          timer_done;

    logic [DIGIT_W-1:0] digit_tbl [CODE_LEN];

    // Split the packed code into a per-position digit table
    for (genvar g = 0; g < CODE_LEN; g++) begin : g_digit
        assign digit_tbl[g] = CODE[DIGIT_W*g +: DIGIT_W];
    end

    // Expected digit and position come straight from idx so the comparator sees the update one cycle later
    assign code_digit = digit_tbl[idx];
    assign digit_idx  = idx;

    // Only a clean one-hot "equal" counts; any other combination is a wrong digit
    assign match = equal && !less && !greater;

    // Unused encoding also forces the timer idle while the controller recovers
    assign state_bad  = !(state inside {ST_ENTRY, ST_OPEN, ST_LOCKOUT});
    assign timer_rst  = sys_rst || state_bad;
    assign lock_start = (state == ST_ENTRY) && key_pulse && !match && (fail_cnt == FAIL_LAST);

    lockout_timer #(
        .LOCKOUT_CYC (LOCKOUT_CYC)
    ) u_lockout_timer (
        .clk        (sys_clk),
        .rst        (timer_rst),
        .start      (lock_start),
        .busy       (timer_busy),
        .done_pulse (timer_done)
    );

    // Lock controller: digit progress, failure bookkeeping and registered LED outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= ST_ENTRY;
            idx        <= '0;
            fail_cnt   <= '0;
            unlock     <= 1'b0;
            fail_pulse <= 1'b0;
            locked_out <= 1'b0;
`ifdef CODE_LOCK_HINT_EN
            hint       <= 2'b00;
`endif
        end else begin
            fail_pulse <= 1'b0;
            case (state)
                ST_ENTRY: begin
                    if (key_pulse) begin
                        if (match) begin
`ifdef CODE_LOCK_HINT_EN
                            hint <= 2'b00;
`endif
                            if (idx == IDX_LAST) begin
                                state    <= ST_OPEN;
                                idx      <= '0;
                                fail_cnt <= '0;
                                unlock   <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            idx        <= '0;
                            fail_pulse <= 1'b1;
                            if (fail_cnt == FAIL_LAST) begin
                                state      <= ST_LOCKOUT;
                                fail_cnt   <= '0;
                                locked_out <= 1'b1;
`ifdef CODE_LOCK_HINT_EN
                                hint       <= 2'b00;
`endif
                            end else begin
                                fail_cnt <= fail_cnt + 1'b1;
`ifdef CODE_LOCK_HINT_EN
                                hint     <= {greater, less};
`endif
                            end
                        end
                    end
                end
                ST_OPEN: begin
                    // Compare results are irrelevant here; any key press re-locks
                    if (key_pulse) begin
                        state  <= ST_ENTRY;
                        idx    <= '0;
                        unlock <= 1'b0;
                    end
                end
                ST_LOCKOUT: begin
                    // Key presses are ignored; an idle timer here can only mean corruption, so leave too
                    if (timer_done || !timer_busy) begin
                        state      <= ST_ENTRY;
                        locked_out <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_ENTRY;
                    idx        <= '0;
                    fail_cnt   <= '0;
                    unlock     <= 1'b0;
                    locked_out <= 1'b0;
`ifdef CODE_LOCK_HINT_EN
                    hint       <= 2'b00;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_lock_fsm.sv
// Testbench for code_lock_fsm: directed scenarios plus random key traffic against a behavioural lock model.
// Expected outputs per clock are queued by the stimulus side and checked by an independent monitor.
// Build with CODE_LOCK_HINT_EN defined to also check the hint port.
module tb_code_lock_fsm;

    localparam int          CODE_LEN    = 4;
    localparam logic [7:0]  CODE        = 8'b00_11_01_10;
    localparam int          MAX_FAIL    = 3;
    localparam int          LOCKOUT_CYC = 10;

    typedef struct packed {
        logic       unlock;
        logic       fail_pulse;
        logic       locked_out;
        logic [1:0] idx;
        logic [1:0] digit;
        logic [1:0] hint;
    } obs_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       key_pulse = 1'b0;
    logic [1:0] num1 = 2'd0;
    logic       force_en = 1'b0;
    logic [2:0] force_bits = 3'b000;   // {less, equal, greater}
    logic       less, equal, greater;
    logic [1:0] code_digit;
    logic [1:0] digit_idx;
    logic       unlock, fail_pulse, locked_out;
    logic [1:0] hint_obs;
`ifdef CODE_LOCK_HINT_EN
    logic [1:0] dut_hint;
    assign hint_obs = dut_hint;
`else
    assign hint_obs = 2'b00;
`endif

    always #5 sys_clk = ~sys_clk;

    // 2-bit magnitude comparator: num1 from the bench, num2 from the lock; bench may override its outputs
    assign less    = force_en ? force_bits[2] : (num1 <  code_digit);
    assign equal   = force_en ? force_bits[1] : (num1 == code_digit);
    assign greater = force_en ? force_bits[0] : (num1 >  code_digit);

    code_lock_fsm #(
        .CODE_LEN    (CODE_LEN),
        .CODE        (CODE),
        .MAX_FAIL    (MAX_FAIL),
        .LOCKOUT_CYC (LOCKOUT_CYC)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_pulse  (key_pulse),
        .less       (less),
        .equal      (equal),
        .greater    (greater),
        .code_digit (code_digit),
        .digit_idx  (digit_idx),
        .unlock     (unlock),
        .fail_pulse (fail_pulse),
        .locked_out (locked_out)
`ifdef CODE_LOCK_HINT_EN
        ,
        .hint       (dut_hint)
`endif
    );

    // ---------------- behavioural model ----------------
    int         m_pos;        // digits correctly entered so far
    int         m_fails;      // wrong attempts since last unlock/lockout
    int         m_lock_left;  // lockout cycles still to run
    bit         m_open;
    bit         m_fp;
    logic [1:0] m_hint;
    obs_t       exp_q [$];
    int         n_cmp = 0;
    int         n_mis = 0;
    int         cyc = 0;

    function automatic logic [1:0] digit_of(input int i);
        logic [7:0] c;
        c = CODE;
        return c[2*i +: 2];
    endfunction

    task automatic model_step(input bit rst, input bit key, input bit lt, input bit eq, input bit gt);
        bit   hit;
        obs_t o;
        hit  = eq && !lt && !gt;
        m_fp = 1'b0;
        if (rst) begin
            m_pos = 0; m_fails = 0; m_lock_left = 0; m_open = 1'b0; m_hint = 2'b00;
        end else if (m_lock_left > 0) begin
            m_lock_left--;
        end else if (m_open) begin
            if (key) begin
                m_open = 1'b0;
                m_pos  = 0;
            end
        end else if (key) begin
            if (hit) begin
                m_hint = 2'b00;
                m_pos++;
                if (m_pos == CODE_LEN) begin
                    m_pos = 0; m_fails = 0; m_open = 1'b1;
                end
            end else begin
                m_pos  = 0;
                m_fp   = 1'b1;
                m_hint = {gt, lt};
                m_fails++;
                if (m_fails == MAX_FAIL) begin
                    m_fails = 0; m_lock_left = LOCKOUT_CYC; m_hint = 2'b00;
                end
            end
        end
        o.unlock     = m_open;
        o.fail_pulse = m_fp;
        o.locked_out = (m_lock_left > 0);
        o.idx        = 2'(m_pos);
        o.digit      = digit_of(m_pos);
`ifdef CODE_LOCK_HINT_EN
        o.hint       = m_hint;
`else
        o.hint       = 2'b00;
`endif
        exp_q.push_back(o);
    endtask

    // Apply one cycle of inputs, queue the expected post-edge outputs, then advance past the edge
    task automatic step(input bit rst, input bit key, input logic [1:0] n1, input bit frc, input logic [2:0] fb);
        bit lt, eq, gt;
        sys_rst = rst; key_pulse = key; num1 = n1; force_en = frc; force_bits = fb;
        if (frc) {lt, eq, gt} = fb;
        else begin
            lt = (n1 <  digit_of(m_pos));
            eq = (n1 == digit_of(m_pos));
            gt = (n1 >  digit_of(m_pos));
        end
        model_step(rst, key, lt, eq, gt);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b0, 3'b000);
    endtask

    task automatic press(input logic [1:0] n1);
        step(1'b0, 1'b1, n1, 1'b0, 3'b000);
        idle(2);
    endtask

    task automatic enter_code();
        for (int i = 0; i < CODE_LEN; i++) press(digit_of(i));
    endtask

    // ---------------- monitor ----------------
    obs_t e, got;
    always @(negedge sys_clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = '{unlock: unlock, fail_pulse: fail_pulse, locked_out: locked_out,
                    idx: digit_idx, digit: code_digit, hint: hint_obs};
            n_cmp++;
            if (got !== e) begin
                n_mis++;
                $display("FAIL outputs cyc=%0d got unlock=%b fail_pulse=%b locked_out=%b idx=%0d digit=%0d hint=%b want unlock=%b fail_pulse=%b locked_out=%b idx=%0d digit=%0d hint=%b",
                         cyc, got.unlock, got.fail_pulse, got.locked_out, got.idx, got.digit, got.hint,
                         e.unlock, e.fail_pulse, e.locked_out, e.idx, e.digit, e.hint);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit         k, f, r;
        logic [1:0] n;
        m_pos = 0; m_fails = 0; m_lock_left = 0; m_open = 1'b0; m_fp = 1'b0; m_hint = 2'b00;

        step(1'b1, 1'b0, 2'd0, 1'b0, 3'b000);
        step(1'b1, 1'b0, 2'd0, 1'b0, 3'b000);
        idle(2);

        // Correct entry, then relock from OPEN
        enter_code();
        idle(3);
        press(2'd0);

        // Mismatch restart on the third digit, then a correct entry
        press(2'd2); press(2'd1); press(2'd0);
        enter_code();
        press(2'd3);

        // Three wrong first digits -> lockout; presses during lockout are ignored
        press(2'd3); press(2'd3); press(2'd3);
        step(1'b0, 1'b1, 2'd2, 1'b0, 3'b000);
        step(1'b0, 1'b1, 2'd3, 1'b0, 3'b000);
        idle(8);
        enter_code();
        press(2'd1);

        // Non-one-hot compare result counts as a miss, even with equal set
        step(1'b0, 1'b1, 2'd2, 1'b1, 3'b110);
        idle(2);
        step(1'b0, 1'b1, 2'd2, 1'b1, 3'b011);
        idle(2);

        // Back-to-back key pulses each compare against the already-advanced digit
        step(1'b1, 1'b0, 2'd0, 1'b0, 3'b000);
        step(1'b0, 1'b1, 2'd2, 1'b0, 3'b000);
        step(1'b0, 1'b1, 2'd1, 1'b0, 3'b000);
        step(1'b0, 1'b1, 2'd3, 1'b0, 3'b000);
        step(1'b0, 1'b1, 2'd0, 1'b0, 3'b000);
        step(1'b0, 1'b1, 2'd0, 1'b0, 3'b000);
        idle(2);

        // Hint: high guess, low guess, then a correct digit
        step(1'b1, 1'b0, 2'd0, 1'b0, 3'b000);
        press(2'd3); press(2'd0); press(2'd2);

        // Reset held two cycles in the middle of a lockout
        press(2'd3);
        idle(4);
        step(1'b1, 1'b0, 2'd0, 1'b0, 3'b000);
        step(1'b1, 1'b0, 2'd0, 1'b0, 3'b000);
        idle(3);
        enter_code();
        press(2'd0);

        // Random traffic, biased towards correct digits so OPEN and LOCKOUT are both reached
        for (int i = 0; i < 1500; i++) begin
            k = ($urandom_range(0, 2) == 0);
            f = ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) n = 2'($urandom_range(0, 3));
            else                           n = digit_of(m_pos);
            step(r, k, n, f, 3'($urandom_range(0, 7)));
        end
        idle(2);

        @(negedge sys_clk);
        #1;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
